// File: rtl/yuv444_to_yuv422.sv
//------------------------------------------------------------------------------
// Module   : yuv444_to_yuv422
// Purpose  : Packs a YUV444 pixel stream to YUV422 (Y + interleaved Cb/Cr) with
//            a fixed 2-cycle latency on all outputs. Define YUV422_CHROMA_AVG_EN
//            to average chroma across each pixel pair instead of decimating it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module yuv444_to_yuv422 #(
   parameter int C_BPC = 8
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             DE_I,
   input  logic             HS_I,
   input  logic             VS_I,
   input  logic [C_BPC-1:0] Y_I,
   input  logic [C_BPC-1:0] U_I,
   input  logic [C_BPC-1:0] V_I,
   output logic             DE_O,
   output logic             HS_O,
   output logic             VS_O,
   output logic [C_BPC-1:0] Y_O,
   output logic [C_BPC-1:0] C_O,
   output logic             ODD_O
);

   // Phase of the next DE pixel; forced even whenever DE is low so a DE rise starts a line
   logic             r_phase;
   logic             r_s1_de;
   logic             r_s1_hs;
   logic             r_s1_vs;
   logic             r_s1_odd;
   logic [C_BPC-1:0] r_s1_y;
   logic [C_BPC-1:0] r_s1_u;
   logic [C_BPC-1:0] r_s1_v;
   logic [C_BPC-1:0] r_s2_v;
   logic [C_BPC-1:0] w_chroma;

`ifdef YUV422_CHROMA_AVG_EN
   logic [C_BPC:0] w_sum_u;
   logic [C_BPC:0] w_sum_v;

   // An even pixel's partner is the pixel at the input right now, present only while DE holds
   always_comb begin
      w_sum_u  = {1'b0, r_s1_u} + {1'b0, U_I}    + {{C_BPC{1'b0}}, 1'b1};
      w_sum_v  = {1'b0, r_s2_v} + {1'b0, r_s1_v} + {{C_BPC{1'b0}}, 1'b1};
      w_chroma = r_s1_u;
      if (r_s1_odd) begin
         w_chroma = w_sum_v[C_BPC:1];
      end else if (DE_I) begin
         w_chroma = w_sum_u[C_BPC:1];
      end
   end
`else
   always_comb begin
      w_chroma = r_s1_odd ? r_s2_v : r_s1_u;
   end
`endif

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_phase  <= 1'b0;
         r_s1_de  <= 1'b0;
         r_s1_hs  <= 1'b0;
         r_s1_vs  <= 1'b0;
         r_s1_odd <= 1'b0;
         r_s1_y   <= '0;
         r_s1_u   <= '0;
         r_s1_v   <= '0;
         r_s2_v   <= '0;
         DE_O     <= 1'b0;
         HS_O     <= 1'b0;
         VS_O     <= 1'b0;
         Y_O      <= '0;
         C_O      <= '0;
         ODD_O    <= 1'b0;
      end else begin
         r_phase  <= DE_I ? ~r_phase : 1'b0;
         r_s1_de  <= DE_I;
         r_s1_hs  <= HS_I;
         r_s1_vs  <= VS_I;
         r_s1_odd <= DE_I & r_phase;
         r_s1_y   <= Y_I;
         r_s1_u   <= U_I;
         r_s1_v   <= V_I;
         r_s2_v   <= r_s1_v;
         DE_O     <= r_s1_de;
         HS_O     <= r_s1_hs;
         VS_O     <= r_s1_vs;
         Y_O      <= r_s1_de ? r_s1_y : '0;
         C_O      <= r_s1_de ? w_chroma : '0;
         ODD_O    <= r_s1_odd;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_yuv444_to_yuv422.sv
//------------------------------------------------------------------------------
// Module   : tb_yuv444_to_yuv422
// Purpose  : Self-checking bench for yuv444_to_yuv422 (both chroma builds).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_yuv444_to_yuv422;

   typedef struct {
      logic       rst;
      logic       de;
      logic       hs;
      logic       vs;
      logic [7:0] y;
      logic [7:0] u;
      logic [7:0] v;
   } stim_t;

   typedef struct {
      int         tid;
      int         row;
      logic       de;
      logic       hs;
      logic       vs;
      logic       odd;
      logic [7:0] y;
      logic [7:0] c;
   } exp_t;

   typedef struct {
      logic [7:0] y;
      logic [7:0] u;
      logic [7:0] v;
      logic [7:0] c_dec;
      logic [7:0] c_avg;
      logic       odd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [7:0] y_i = '0, u_i = '0, v_i = '0;
   logic       de_o, hs_o, vs_o, odd_o;
   logic [7:0] y_o, c_o;

   int n_cmp = 0;
   int n_err = 0;

   stim_t seq[$];
   exp_t  ex[$];
   exp_t  sb[$];

   always #5 clk = ~clk;

   yuv444_to_yuv422 #(.C_BPC(8)) dut (
      .CLK_I(clk), .RST_I(rst), .DE_I(de), .HS_I(hs), .VS_I(vs),
      .Y_I(y_i), .U_I(u_i), .V_I(v_i),
      .DE_O(de_o), .HS_O(hs_o), .VS_O(vs_o), .Y_O(y_o), .C_O(c_o), .ODD_O(odd_o)
   );

   function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b} + 9'd1;
      return s[8:1];
   endfunction

   function automatic void add(input logic r, input logic d, input logic h, input logic v,
                               input logic [7:0] yy, input logic [7:0] uu, input logic [7:0] vv);
      stim_t s;
      s.rst = r; s.de = d; s.hs = h; s.vs = v; s.y = yy; s.u = uu; s.v = vv;
      seq.push_back(s);
   endfunction

   function automatic logic [7:0] rnd8();
      return 8'($urandom_range(0, 255));
   endfunction

   // Sequence-level reference: pair position counted from the start of each DE run
   function automatic exp_t model(input int tid, input int i);
      exp_t e;
      int   pos;
      logic partner;
      e.tid = tid; e.row = i;
      e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.odd = 1'b0; e.y = '0; e.c = '0;
      if (seq[i].rst || (i + 1 < seq.size() && seq[i+1].rst)) return e;
      e.hs = seq[i].hs;
      e.vs = seq[i].vs;
      if (!seq[i].de) return e;
      pos = 0;
      for (int j = i - 1; j >= 0; j--) begin
         if (!seq[j].de || seq[j].rst) break;
         pos++;
      end
      e.de  = 1'b1;
      e.y   = seq[i].y;
      e.odd = pos[0];
      partner = (i + 1 < seq.size()) && seq[i+1].de && !seq[i+1].rst;
`ifdef YUV422_CHROMA_AVG_EN
      if (!e.odd) e.c = partner ? avg(seq[i].u, seq[i+1].u) : seq[i].u;
      else        e.c = avg(seq[i-1].v, seq[i].v);
`else
      if (!e.odd) e.c = seq[i].u;
      else        e.c = seq[i-1].v;
`endif
      return e;
   endfunction

   task automatic check(input exp_t e);
      n_cmp++;
      if (de_o !== e.de || hs_o !== e.hs || vs_o !== e.vs || odd_o !== e.odd ||
          y_o !== e.y || c_o !== e.c) begin
         n_err++;
         $display("FAIL t%0d row %0d: got de=%b hs=%b vs=%b y=%0d c=%0d odd=%b, want de=%b hs=%b vs=%b y=%0d c=%0d odd=%b",
                  e.tid, e.row, de_o, hs_o, vs_o, y_o, c_o, odd_o,
                  e.de, e.hs, e.vs, e.y, e.c, e.odd);
      end
   endtask

   // One clock: compare the output due now (entry pushed two cycles ago), then drive and push
   task automatic cyc(input stim_t s, input exp_t e);
      @(negedge clk);
      if (sb.size() >= 2) check(sb.pop_front());
      rst = s.rst; de = s.de; hs = s.hs; vs = s.vs;
      y_i = s.y; u_i = s.u; v_i = s.v;
      sb.push_back(e);
   endtask

   task automatic run_list();
      for (int i = 0; i < seq.size(); i++) cyc(seq[i], ex[i]);
      seq.delete();
      ex.delete();
   endtask

   task automatic run_model(input int tid);
      for (int i = 0; i < seq.size(); i++) ex.push_back(model(tid, i));
      run_list();
   endtask

   initial begin
      vec_t tab[4];
      exp_t e;

      // t1: reset held 3 cycles under random inputs
      for (int i = 0; i < 3; i++)
         add(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rnd8(), rnd8(), rnd8());
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      run_model(1);

      // t2: table-driven 4-pixel line
      tab[0] = '{y: 8'd1, u: 8'd10, v: 8'd50, c_dec: 8'd10, c_avg: 8'd15, odd: 1'b0};
      tab[1] = '{y: 8'd2, u: 8'd20, v: 8'd60, c_dec: 8'd50, c_avg: 8'd55, odd: 1'b1};
      tab[2] = '{y: 8'd3, u: 8'd30, v: 8'd70, c_dec: 8'd30, c_avg: 8'd35, odd: 1'b0};
      tab[3] = '{y: 8'd4, u: 8'd40, v: 8'd80, c_dec: 8'd70, c_avg: 8'd75, odd: 1'b1};
      for (int i = 0; i < 4; i++) begin
         add(1'b0, 1'b1, 1'b0, 1'b0, tab[i].y, tab[i].u, tab[i].v);
         e.tid = 2; e.row = i; e.de = 1'b1; e.hs = 1'b0; e.vs = 1'b0;
         e.y = tab[i].y; e.odd = tab[i].odd;
`ifdef YUV422_CHROMA_AVG_EN
         e.c = tab[i].c_avg;
`else
         e.c = tab[i].c_dec;
`endif
         ex.push_back(e);
      end
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      e.tid = 2; e.row = 4; e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.y = '0; e.c = '0; e.odd = 1'b0;
      ex.push_back(e);
      run_list();

      // t3: odd-length line then a 2-pixel line
      add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), 8'd100, rnd8());
      add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), 8'd200, rnd8());
      add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), 8'd255, rnd8());
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), rnd8(), rnd8());
      add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), rnd8(), rnd8());
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      run_model(3);

      // t4: rounding / saturation pairs
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd255, 8'd255);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd255, 8'd255);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd0, 8'd0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd1, 8'd1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd254, 8'd254);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd255, 8'd255);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      run_model(4);

      // t5: DE gap restarts the pair phase
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), rnd8(), rnd8());
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      for (int i = 0; i < 2; i++) add(1'b0, 1'b1, 1'b0, 1'b0, rnd8(), rnd8(), rnd8());
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      run_model(5);

      // t6: reset on pixel 5 of 8, line restarts after release
      for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b0, rnd8(), rnd8(), rnd8());
      add(1'b1, 1'b1, 1'b1, 1'b0, rnd8(), rnd8(), rnd8());
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, 1'b0, rnd8(), rnd8(), rnd8());
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      run_model(6);

      // t7: random lines with sync toggling inside DE and random gaps
      for (int l = 0; l < 6; l++) begin
         int len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++)
            add(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8());
         for (int i = 0; i < int'($urandom_range(1, 3)); i++)
            add(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8());
      end
      run_model(7);

      // drain the last two scoreboard entries
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      run_model(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
